// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants for the two-requester memory port arbiter.
//   - FSM state encoding (IDLE / ACCESS / WAIT)
//   - transaction owner encoding (instruction fetch vs data port)
package mem_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_arb_prio_sel.sv
// mem_arb_prio_sel: winner select for the memory port arbiter.
// Data requests win by default; a saturating starvation counter forces the
// fetch side to win once it has lost STARVE_MAX consecutive grants to D.
// Ports:
//   arb_clk_i  clock
//   arb_rst_i  asynchronous active-low reset
//   if_req_i   fetch request
//   d_req_i    data request
//   grant_i    a grant is being issued this cycle
//   winner_o   OWN_IF or OWN_D, meaningful while grant_i is high
module mem_arb_prio_sel
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 32'd4
) (
  input  logic arb_clk_i,
  input  logic arb_rst_i,
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic grant_i,
  output logic winner_o
);

  localparam int unsigned        CNT_W   = $clog2(STARVE_MAX + 32'd1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(32'd1);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;

  // Winner select: IF wins when alone, or when D has starved it long enough
  always_comb begin
    winner_o = OWN_D;
    if (if_req_i && (!d_req_i || (starve_q == CNT_MAX))) begin
      winner_o = OWN_IF;
    end else begin
      winner_o = OWN_D;
    end
  end

  // Starvation count: counts D grants that left IF waiting, saturating
  always_comb begin
    starve_d = starve_q;
    if (grant_i) begin
      if ((winner_o == OWN_D) && if_req_i) begin
        if (starve_q == CNT_MAX) begin
          starve_d = starve_q;
        end else begin
          starve_d = starve_q + CNT_ONE;
        end
      end else begin
        starve_d = {CNT_W{1'b0}};
      end
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register
  always_ff @(posedge arb_clk_i or negedge arb_rst_i) begin
    if (!arb_rst_i) begin
      starve_q <= {CNT_W{1'b0}};
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF)
// and data load/store (D). One transaction is outstanding at a time:
// IDLE grants (combinational gnt), ACCESS strobes mem_en for one cycle,
// WAIT counts down the remaining memory latency. The owner's rvalid pulses
// MEM_LAT+1 cycles after its grant, and a new grant may issue in that cycle.
// Ports:
//   arb_clk / arb_rst              clock, asynchronous active-low reset
//   if_req/if_addr -> if_gnt       fetch request and accept pulse
//   if_rvalid/if_rdata             fetch response (rdata held)
//   d_req/d_we/d_addr/d_wdata      data request fields -> d_gnt
//   d_rvalid/d_rdata               load data or store completion
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory port
//   busy                           high while a transaction is in flight
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32'd32,
  parameter int unsigned DATA_W     = 32'd32,
  parameter int unsigned MEM_LAT    = 32'd2,
  parameter int unsigned STARVE_MAX = 32'd4
) (
  input  logic              arb_clk,
  input  logic              arb_rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned      LAT_W      = $clog2(MEM_LAT + 32'd1);
  localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MEM_LAT - 32'd1);
  localparam logic [LAT_W-1:0] LAT_ONE    = LAT_W'(32'd1);
  localparam logic             SINGLE_CYC = (MEM_LAT == 32'd1);

  logic [1:0]        state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              owner_q;
  logic              txn_we_q;
  logic              grant_s;
  logic              winner_s;
  logic              capture_s;
  logic              mem_en_q, mem_we_q, busy_q;
  logic              if_rvalid_q, d_rvalid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;

  mem_arb_prio_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio_sel (
    .arb_clk_i (arb_clk),
    .arb_rst_i (arb_rst),
    .if_req_i  (if_req),
    .d_req_i   (d_req),
    .grant_i   (grant_s),
    .winner_o  (winner_s)
  );

  // The grant is combinational; the reset term keeps gnt low while held in reset.
  assign grant_s   = (state_q == IDLE) && (if_req || d_req);
  assign if_gnt    = arb_rst && grant_s && (winner_s == OWN_IF);
  assign d_gnt     = arb_rst && grant_s && (winner_s == OWN_D);
  // Read data is sampled in the last latency cycle (ACCESS itself when MEM_LAT=1).
  assign capture_s = ((state_q == ACCESS) && SINGLE_CYC) ||
                     ((state_q == WAIT) && (lat_q == LAT_ONE));

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;

  // FSM next state and latency countdown
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (SINGLE_CYC) begin
          state_d = IDLE;
        end else begin
          lat_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        lat_d = lat_q - LAT_ONE;
        if (lat_q == LAT_ONE) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
        lat_d   = {LAT_W{1'b0}};
      end
    endcase
  end

  // FSM state and latency counter registers
  always_ff @(posedge arb_clk or negedge arb_rst) begin
    if (!arb_rst) begin
      state_q <= IDLE;
      lat_q   <= {LAT_W{1'b0}};
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // Memory port, owner tracking and response registers
  always_ff @(posedge arb_clk or negedge arb_rst) begin
    if (!arb_rst) begin
      owner_q     <= OWN_IF;
      txn_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= {DATA_W{1'b0}};
      d_rdata_q   <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      // mem_en/mem_we are high exactly in the ACCESS cycle following a grant
      mem_en_q <= grant_s;
      mem_we_q <= grant_s && (winner_s == OWN_D) && d_we;
      if (grant_s) begin
        owner_q    <= winner_s;
        txn_we_q   <= (winner_s == OWN_D) && d_we;
        mem_addr_q <= (winner_s == OWN_IF) ? if_addr : d_addr;
        // Fetches carry no write data, so the last store data is kept
        if (winner_s == OWN_D) begin
          mem_wdata_q <= d_wdata;
        end
      end
      if_rvalid_q <= capture_s && (owner_q == OWN_IF);
      d_rvalid_q  <= capture_s && (owner_q == OWN_D);
      if (capture_s && (owner_q == OWN_IF)) begin
        if_rdata_q <= mem_rdata;
      end
      // Stores complete with d_rvalid but leave d_rdata untouched
      if (capture_s && (owner_q == OWN_D) && !txn_we_q) begin
        d_rdata_q <= mem_rdata;
      end
      busy_q <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a MEM_LAT=2 instance (index 0) and a MEM_LAT=1
// instance (index 1) checked every cycle against a transaction-timing model,
// plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  localparam int SM = 4;

  logic        arb_clk;
  logic        arb_rst;
  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [31:0] d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic [31:0] mem_rdata [2];
  logic        if_gnt    [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata  [2];
  logic        d_gnt     [2];
  logic        d_rvalid  [2];
  logic [31:0] d_rdata   [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic        busy      [2];

  int total;
  int bad;
  int cyc;

  // Reference model: timing derived from grant cycle T (mem_en at T+1,
  // data sampled at T+MEM_LAT, response at T+MEM_LAT+1, next grant from then).
  int          m_free     [2];
  int          m_starve   [2];
  int          m_en_cyc   [2];
  int          m_data_cyc [2];
  int          m_resp_cyc [2];
  bit          m_en_we    [2];
  bit          m_own_d    [2];
  bit          m_we       [2];
  bit          m_gnt_if   [2];
  bit          m_gnt_d    [2];
  logic [31:0] m_pend     [2];
  logic [31:0] m_addr     [2];
  logic [31:0] m_wdata    [2];
  logic [31:0] m_if_rdata [2];
  logic [31:0] m_d_rdata  [2];

  logic        rec_if  [$];
  int          rec_cyc [$];
  bit          exp_if  [10];
  logic [31:0] prev_d;
  int          n_if;

  mem_port_arbiter #(.ADDR_W(32'd32), .DATA_W(32'd32), .MEM_LAT(32'd2), .STARVE_MAX(32'd4)) u_dut_lat2 (
    .arb_clk(arb_clk), .arb_rst(arb_rst),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.ADDR_W(32'd32), .DATA_W(32'd32), .MEM_LAT(32'd1), .STARVE_MAX(32'd4)) u_dut_lat1 (
    .arb_clk(arb_clk), .arb_rst(arb_rst),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  initial arb_clk = 1'b0;
  always #5 arb_clk = ~arb_clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic string mtag(input string s, input int k);
    return $sformatf("%s%0d", s, k);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outs(input int k);
    check_eq(mtag("rst_if_gnt", k),    32'(if_gnt[k]),    32'd0);
    check_eq(mtag("rst_d_gnt", k),     32'(d_gnt[k]),     32'd0);
    check_eq(mtag("rst_if_rvalid", k), 32'(if_rvalid[k]), 32'd0);
    check_eq(mtag("rst_d_rvalid", k),  32'(d_rvalid[k]),  32'd0);
    check_eq(mtag("rst_if_rdata", k),  if_rdata[k],       32'd0);
    check_eq(mtag("rst_d_rdata", k),   d_rdata[k],        32'd0);
    check_eq(mtag("rst_mem_en", k),    32'(mem_en[k]),    32'd0);
    check_eq(mtag("rst_mem_we", k),    32'(mem_we[k]),    32'd0);
    check_eq(mtag("rst_mem_addr", k),  mem_addr[k],       32'd0);
    check_eq(mtag("rst_mem_wdata", k), mem_wdata[k],      32'd0);
    check_eq(mtag("rst_busy", k),      32'(busy[k]),      32'd0);
  endtask

  task automatic model_reset(input int k);
    m_free[k]     = 0;
    m_starve[k]   = 0;
    m_en_cyc[k]   = -1;
    m_data_cyc[k] = -1;
    m_resp_cyc[k] = -1;
    m_en_we[k]    = 1'b0;
    m_own_d[k]    = 1'b0;
    m_we[k]       = 1'b0;
    m_gnt_if[k]   = 1'b0;
    m_gnt_d[k]    = 1'b0;
    m_pend[k]     = 32'd0;
    m_addr[k]     = 32'd0;
    m_wdata[k]    = 32'd0;
    m_if_rdata[k] = 32'd0;
    m_d_rdata[k]  = 32'd0;
  endtask

  task automatic model_step(input int k);
    int lat;
    bit take_if;
    bit en;
    lat = lat_of(k);
    if (cyc == m_resp_cyc[k]) begin
      if (!m_own_d[k]) m_if_rdata[k] = m_pend[k];
      else if (!m_we[k]) m_d_rdata[k] = m_pend[k];
    end
    take_if     = 1'b0;
    m_gnt_if[k] = 1'b0;
    m_gnt_d[k]  = 1'b0;
    if ((if_req[k] || d_req[k]) && (cyc >= m_free[k])) begin
      take_if     = if_req[k] && (!d_req[k] || (m_starve[k] == SM));
      m_gnt_if[k] = take_if;
      m_gnt_d[k]  = !take_if;
    end
    en = (cyc == m_en_cyc[k]);
    check_eq(mtag("if_gnt", k),    32'(if_gnt[k]),    32'(m_gnt_if[k]));
    check_eq(mtag("d_gnt", k),     32'(d_gnt[k]),     32'(m_gnt_d[k]));
    check_eq(mtag("mem_en", k),    32'(mem_en[k]),    32'(en));
    check_eq(mtag("mem_we", k),    32'(mem_we[k]),    32'(en && m_en_we[k]));
    check_eq(mtag("mem_addr", k),  mem_addr[k],       m_addr[k]);
    if (en && m_en_we[k]) check_eq(mtag("mem_wdata", k), mem_wdata[k], m_wdata[k]);
    check_eq(mtag("busy", k),      32'(busy[k]),      32'(cyc < m_free[k]));
    check_eq(mtag("if_rvalid", k), 32'(if_rvalid[k]), 32'((cyc == m_resp_cyc[k]) && !m_own_d[k]));
    check_eq(mtag("d_rvalid", k),  32'(d_rvalid[k]),  32'((cyc == m_resp_cyc[k]) && m_own_d[k]));
    check_eq(mtag("if_rdata", k),  if_rdata[k],       m_if_rdata[k]);
    check_eq(mtag("d_rdata", k),   d_rdata[k],        m_d_rdata[k]);
    if (cyc == m_data_cyc[k]) m_pend[k] = mem_rdata[k];
    if (m_gnt_if[k] || m_gnt_d[k]) begin
      m_own_d[k] = !take_if;
      m_we[k]    = !take_if && d_we[k];
      m_addr[k]  = take_if ? if_addr[k] : d_addr[k];
      if (!take_if) m_wdata[k] = d_wdata[k];
      m_en_cyc[k]   = cyc + 1;
      m_en_we[k]    = m_we[k];
      m_data_cyc[k] = cyc + lat;
      m_resp_cyc[k] = cyc + lat + 1;
      m_free[k]     = cyc + lat + 1;
      if (take_if || !if_req[k]) m_starve[k] = 0;
      else if (m_starve[k] < SM) m_starve[k] = m_starve[k] + 1;
    end
  endtask

  // Mid-cycle check of both instances against the model
  task automatic sample();
    @(negedge arb_clk);
    for (int k = 0; k < 2; k++) begin
      if (!arb_rst) begin
        check_reset_outs(k);
        model_reset(k);
      end else begin
        model_step(k);
      end
    end
  endtask

  task automatic advance();
    @(posedge arb_clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) mem_rdata[k] = $urandom;
  endtask

  task automatic drive_random(input int k);
    if (if_req[k] && (m_gnt_if[k] || ($urandom_range(0, 15) == 0))) begin
      if_req[k] = 1'b0;
    end else if (!if_req[k] && ($urandom_range(0, 2) == 0)) begin
      if_req[k]  = 1'b1;
      if_addr[k] = $urandom & 32'hFFFF_FFFC;
    end
    if (d_req[k] && (m_gnt_d[k] || ($urandom_range(0, 15) == 0))) begin
      d_req[k] = 1'b0;
    end else if (!d_req[k] && ($urandom_range(0, 1) == 0)) begin
      d_req[k]   = 1'b1;
      d_we[k]    = 1'($urandom_range(0, 1));
      d_addr[k]  = $urandom & 32'hFFFF_FFFC;
      d_wdata[k] = $urandom;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    exp_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    arb_rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1'b0; if_addr[k] = 32'd0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_addr[k] = 32'd0; d_wdata[k] = 32'd0; mem_rdata[k] = 32'd0;
      model_reset(k);
    end
    repeat (2) begin sample(); advance(); end
    arb_rst = 1'b1;
    sample(); advance();

    // Fetch on the MEM_LAT=2 instance
    if_req[0] = 1'b1; if_addr[0] = 32'h100;
    sample(); check_eq("fetch_gnt", 32'(if_gnt[0]), 32'd1);
    advance(); if_req[0] = 1'b0;
    sample();
    check_eq("fetch_en", 32'(mem_en[0]), 32'd1);
    check_eq("fetch_we", 32'(mem_we[0]), 32'd0);
    check_eq("fetch_addr", mem_addr[0], 32'h100);
    advance(); mem_rdata[0] = 32'h0050_0093;
    sample(); advance();
    sample();
    check_eq("fetch_rvalid", 32'(if_rvalid[0]), 32'd1);
    check_eq("fetch_rdata", if_rdata[0], 32'h0050_0093);
    advance();

    // Both requesters together: D first, IF right behind
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h40; if_req[0] = 1'b1; if_addr[0] = 32'h104;
    for (int i = 0; i < 7; i++) begin
      sample();
      if (i == 0) begin
        check_eq("both_d_gnt", 32'(d_gnt[0]), 32'd1);
        check_eq("both_if_wait", 32'(if_gnt[0]), 32'd0);
      end
      if (i == 3) begin
        check_eq("both_d_rvalid", 32'(d_rvalid[0]), 32'd1);
        check_eq("both_if_gnt", 32'(if_gnt[0]), 32'd1);
      end
      if (i == 6) check_eq("both_if_rvalid", 32'(if_rvalid[0]), 32'd1);
      advance();
      if (m_gnt_d[0]) d_req[0] = 1'b0;
      if (m_gnt_if[0]) if_req[0] = 1'b0;
    end

    // Store leaves d_rdata alone
    prev_d = m_d_rdata[0];
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h80; d_wdata[0] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      sample();
      if (i == 1) begin
        check_eq("store_en", 32'(mem_en[0]), 32'd1);
        check_eq("store_we", 32'(mem_we[0]), 32'd1);
        check_eq("store_wdata", mem_wdata[0], 32'hDEAD_BEEF);
      end
      if (i == 3) begin
        check_eq("store_rvalid", 32'(d_rvalid[0]), 32'd1);
        check_eq("store_rdata_kept", d_rdata[0], prev_d);
      end
      advance();
      if (m_gnt_d[0]) d_req[0] = 1'b0;
    end

    // Starvation: both held high
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h300; if_req[0] = 1'b1; if_addr[0] = 32'h200;
    for (int i = 0; i < 30; i++) begin
      sample();
      if (if_gnt[0] || d_gnt[0]) begin
        rec_if.push_back(if_gnt[0]);
        rec_cyc.push_back(cyc);
      end
      advance();
      if (m_gnt_if[0]) if_addr[0] = if_addr[0] + 32'd4;
      if (m_gnt_d[0]) d_addr[0] = d_addr[0] + 32'd4;
    end
    check_eq("starve_ngrants", rec_if.size(), 32'd10);
    for (int i = 0; i < 10 && i < rec_if.size(); i++) begin
      check_eq(mtag("starve_order", i), 32'(rec_if[i]), 32'(exp_if[i]));
      if (i > 0) check_eq(mtag("starve_gap", i), rec_cyc[i] - rec_cyc[i-1], 32'd3);
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    repeat (3) begin sample(); advance(); end

    // Reset in the middle of a load
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h44;
    sample(); check_eq("rst_load_gnt", 32'(d_gnt[0]), 32'd1);
    advance(); d_req[0] = 1'b0;
    sample(); advance();
    if_req[0] = 1'b1; if_addr[0] = 32'h500;
    arb_rst = 1'b0;
    #1;
    check_reset_outs(0);
    sample(); advance();
    arb_rst = 1'b1;
    sample(); check_eq("post_rst_if_gnt", 32'(if_gnt[0]), 32'd1);
    advance(); if_req[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample(); check_eq(mtag("no_stale_d_rvalid", i), 32'(d_rvalid[0]), 32'd0);
      advance();
    end

    // MEM_LAT=1 instance: continuous fetch, one-cycle d_req while busy
    if_req[1] = 1'b1; if_addr[1] = 32'h600;
    n_if = 0;
    for (int i = 0; i < 12; i++) begin
      sample();
      if (if_gnt[1]) n_if++;
      if (i == 3) begin
        check_eq("lat1_busy", 32'(busy[1]), 32'd1);
        check_eq("lat1_no_d_gnt", 32'(d_gnt[1]), 32'd0);
      end
      advance();
      if (m_gnt_if[1]) if_addr[1] = if_addr[1] + 32'd4;
      if (i == 2) begin d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h700; end
      if (i == 3) d_req[1] = 1'b0;
    end
    check_eq("lat1_if_gnt_count", n_if, 32'd6);
    if_req[1] = 1'b0;
    repeat (2) begin sample(); advance(); end

    // Randomized traffic on both instances
    for (int i = 0; i < 2000; i++) begin
      sample(); advance();
      drive_random(0);
      drive_random(1);
    end
    for (int k = 0; k < 2; k++) begin if_req[k] = 1'b0; d_req[k] = 1'b0; end
    repeat (4) begin sample(); advance(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
